// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared types and constants for the UART-to-ALU command sequencer.
// Opcode bytes, ALU operation encoding and controller state encoding.
package alu_cmd_ctrl_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_MUL  = 2'd2,
        ALU_PASS = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_ECHO,
        ST_OPND,
        ST_EXEC,
        ST_WAIT,
        ST_SEND,
        ST_ERR
    } ctrl_state_e;

    localparam logic [7:0] OPC_ECHO = 8'hEC;
    localparam logic [7:0] OPC_ADD  = 8'hAD;
    localparam logic [7:0] OPC_SUB  = 8'h5B;
    localparam logic [7:0] OPC_MUL  = 8'h4C;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    function automatic logic opc_is_valid(input logic [7:0] b);
        return (b == OPC_ECHO) || (b == OPC_ADD) || (b == OPC_SUB) || (b == OPC_MUL);
    endfunction

    function automatic alu_op_e opc_to_op(input logic [7:0] b);
        case (b)
            OPC_ADD: return ALU_ADD;
            OPC_SUB: return ALU_SUB;
            OPC_MUL: return ALU_MUL;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_ctrl_txser.sv
// LSB-first serialiser feeding uart_tx; holds one word (or one single byte)
// and presents its bytes one at a time on an AXI-stream style handshake.
module alu_cmd_ctrl_txser #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OPND_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ld_byte_i,
    input  logic [DATA_WIDTH-1:0] byte_i,
    input  logic                  ld_word_i,
    input  logic [OPND_WIDTH-1:0] word_i,
    output logic [DATA_WIDTH-1:0] tx_tdata_o,
    output logic                  tx_tvalid_o,
    input  logic                  tx_tready_i,
    output logic                  done_o
);

    localparam int unsigned NB = OPND_WIDTH / DATA_WIDTH;
    localparam int unsigned CW = $clog2(NB + 1);

    logic [OPND_WIDTH-1:0] sr_q;
    logic [CW-1:0]         cnt_q;
    logic                  fire;

    assign tx_tvalid_o = (cnt_q != '0);
    assign tx_tdata_o  = sr_q[DATA_WIDTH-1:0];
    assign fire        = tx_tvalid_o && tx_tready_i;
    assign done_o      = fire && (cnt_q == CW'(1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (ld_word_i) begin
            sr_q  <= word_i;
            cnt_q <= CW'(NB);
        end else if (ld_byte_i) begin
            sr_q  <= OPND_WIDTH'(byte_i);
            cnt_q <= CW'(1);
        end else if (fire) begin
            sr_q  <= sr_q >> DATA_WIDTH;
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command sequencer: parses framed rx commands, folds operands through an
// external ALU via req/gnt, and returns results (or echoed bytes) on tx.
module alu_cmd_ctrl
    import alu_cmd_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OPND_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] rx_tdata_i,
    input  logic                  rx_tvalid_i,
    output logic                  rx_tready_o,
    output logic [DATA_WIDTH-1:0] tx_tdata_o,
    output logic                  tx_tvalid_o,
    input  logic                  tx_tready_i,
    output logic                  alu_req_o,
    input  logic                  alu_gnt_i,
    output logic [1:0]            alu_op_o,
    output logic [OPND_WIDTH-1:0] alu_a_o,
    output logic [OPND_WIDTH-1:0] alu_b_o,
    input  logic [OPND_WIDTH-1:0] alu_res_i,
    input  logic                  alu_res_valid_i,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int unsigned NB  = OPND_WIDTH / DATA_WIDTH;
    localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;

    ctrl_state_e           state_q;
    alu_op_e               op_q;
    logic                  is_echo_q;
    logic [DATA_WIDTH-1:0] len_q;
    logic [DATA_WIDTH-1:0] opnd_cnt_q;
    logic [DATA_WIDTH-1:0] echo_cnt_q;
    logic [BCW-1:0]        byte_cnt_q;
    logic [OPND_WIDTH-1:0] opnd_sr_q;
    logic [OPND_WIDTH-1:0] acc_q;
    logic [OPND_WIDTH-1:0] alu_a_q, alu_b_q;
    logic                  alu_req_q, err_q;

    logic                  rx_fire, last_byte, res_take, fold_done, go_err;
    logic                  ld_byte, ld_word, ser_done;
    logic [DATA_WIDTH-1:0] byte_val;
    logic [OPND_WIDTH-1:0] word_val, opnd_word;

    assign rx_tready_o = (state_q == ST_IDLE) || (state_q == ST_LEN) || (state_q == ST_OPND) ||
                         ((state_q == ST_ECHO) && !tx_tvalid_o);
    assign busy_o      = (state_q != ST_IDLE);
    assign err_o       = err_q;
    assign alu_req_o   = alu_req_q;
    assign alu_op_o    = op_q;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;

    // Serialiser loads are decided combinationally so tx is valid the cycle after the triggering event.
    always_comb begin
        rx_fire   = rx_tvalid_i && rx_tready_o;
        opnd_word = {rx_tdata_i, opnd_sr_q[OPND_WIDTH-1:DATA_WIDTH]};
        last_byte = rx_fire && (state_q == ST_OPND) && (byte_cnt_q == BCW'(NB - 1));
        res_take  = alu_res_valid_i &&
                    ((state_q == ST_WAIT) || ((state_q == ST_EXEC) && alu_gnt_i));
        fold_done = (opnd_cnt_q == len_q);
        go_err    = rx_fire && (((state_q == ST_IDLE) && !opc_is_valid(rx_tdata_i)) ||
                                ((state_q == ST_LEN) && (rx_tdata_i == '0)));
        ld_byte   = 1'b0;
        byte_val  = rx_tdata_i;
        ld_word   = 1'b0;
        word_val  = opnd_word;
        if (go_err) begin
            ld_byte  = 1'b1;
            byte_val = ERR_BYTE;
        end else if ((state_q == ST_ECHO) && rx_fire) begin
            ld_byte  = 1'b1;
        end
        if (last_byte && (opnd_cnt_q == '0) && (len_q == DATA_WIDTH'(1))) begin
            ld_word  = 1'b1;
        end else if (res_take && fold_done) begin
            ld_word  = 1'b1;
            word_val = alu_res_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            op_q       <= ALU_ADD;
            is_echo_q  <= 1'b0;
            len_q      <= '0;
            opnd_cnt_q <= '0;
            echo_cnt_q <= '0;
            byte_cnt_q <= '0;
            opnd_sr_q  <= '0;
            acc_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_req_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (rx_fire) begin
                    if (go_err) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        op_q      <= opc_to_op(rx_tdata_i);
                        is_echo_q <= (rx_tdata_i == OPC_ECHO);
                        state_q   <= ST_LEN;
                    end
                end
                ST_LEN: if (rx_fire) begin
                    len_q      <= rx_tdata_i;
                    opnd_cnt_q <= '0;
                    echo_cnt_q <= '0;
                    byte_cnt_q <= '0;
                    if (go_err) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= is_echo_q ? ST_ECHO : ST_OPND;
                    end
                end
                ST_ECHO: begin
                    if (rx_fire) echo_cnt_q <= echo_cnt_q + 1'b1;
                    if (ser_done && (echo_cnt_q == len_q)) state_q <= ST_IDLE;
                end
                ST_OPND: if (rx_fire) begin
                    opnd_sr_q  <= opnd_word;
                    byte_cnt_q <= byte_cnt_q + 1'b1;
                    if (last_byte) begin
                        byte_cnt_q <= '0;
                        opnd_cnt_q <= opnd_cnt_q + 1'b1;
                        if (opnd_cnt_q == '0) begin
                            acc_q <= opnd_word;
                            if (len_q == DATA_WIDTH'(1)) state_q <= ST_SEND;
                        end else begin
                            alu_a_q   <= acc_q;
                            alu_b_q   <= opnd_word;
                            alu_req_q <= 1'b1;
                            state_q   <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: if (alu_gnt_i) begin
                    alu_req_q <= 1'b0;
                    if (res_take) begin
                        acc_q   <= alu_res_i;
                        state_q <= fold_done ? ST_SEND : ST_OPND;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: if (res_take) begin
                    acc_q   <= alu_res_i;
                    state_q <= fold_done ? ST_SEND : ST_OPND;
                end
                ST_SEND, ST_ERR: if (ser_done) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    alu_cmd_ctrl_txser #(
        .DATA_WIDTH (DATA_WIDTH),
        .OPND_WIDTH (OPND_WIDTH)
    ) u_txser (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .ld_byte_i   (ld_byte),
        .byte_i      (byte_val),
        .ld_word_i   (ld_word),
        .word_i      (word_val),
        .tx_tdata_o  (tx_tdata_o),
        .tx_tvalid_o (tx_tvalid_o),
        .tx_tready_i (tx_tready_i),
        .done_o      (ser_done)
    );

endmodule
